// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU-operation decode stage:
//                ALU operation codes, RV32I major opcodes and funct7 values.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_OP_WIDTH = 6;

  // ALU operation codes consumed by the datapath ALU
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 6'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_JUMP = 6'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BEQ  = 6'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BNE  = 6'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 6'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BGE  = 6'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 6'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BGEU = 6'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 6'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 6'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 6'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 6'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 6'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 6'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 6'd14;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode_comb
//  Description : Purely combinational RV32I instruction -> ALU control
//                bundle classifier.
//  Ports       : i_instr     RV32I instruction word
//                o_alu_op    ALU operation code
//                o_op_a_pc   operand A is the PC
//                o_op_b_imm  operand B is the immediate
//                o_is_branch conditional branch
//                o_illegal   unsupported encoding (all other fields forced 0)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode_comb
  import alu_pkg::*;
#(
  parameter int ALU_OP_WIDTH = alu_pkg::ALU_OP_WIDTH
) (
  input  logic [31:0]             i_instr,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic                    o_op_a_pc,
  output logic                    o_op_b_imm,
  output logic                    o_is_branch,
  output logic                    o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_f7_base;
  logic       w_f7_alt;

  logic [alu_pkg::ALU_OP_WIDTH-1:0] w_op;
  logic w_a_pc;
  logic w_b_imm;
  logic w_branch;
  logic w_ill;

  // Register indices and immediate bits play no part in classification
  logic w_unused_fields;
  assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

  assign w_opcode  = i_instr[6:0];
  assign w_funct3  = i_instr[14:12];
  assign w_funct7  = i_instr[31:25];
  assign w_f7_base = (w_funct7 == F7_BASE);
  assign w_f7_alt  = (w_funct7 == F7_ALT);

  always_comb begin
    w_op     = ALU_ADD;
    w_a_pc   = 1'b0;
    w_b_imm  = 1'b0;
    w_branch = 1'b0;
    w_ill    = 1'b0;

    case (w_opcode)
      OPC_OP: begin
        case (w_funct3)
          3'b000: begin
            // funct7=0100000 turns ADD into SUB
            if (w_f7_alt)       w_op = ALU_SUB;
            else if (w_f7_base) w_op = ALU_ADD;
            else                w_ill = 1'b1;
          end
          3'b101: begin
            if (w_f7_alt)       w_op = ALU_SRA;
            else if (w_f7_base) w_op = ALU_SRL;
            else                w_ill = 1'b1;
          end
          default: begin
            // Remaining R-type ops accept only the base funct7
            w_ill = !w_f7_base;
            case (w_funct3)
              3'b001:  w_op = ALU_SLL;
              3'b010:  w_op = ALU_SLT;
              3'b011:  w_op = ALU_SLTU;
              3'b100:  w_op = ALU_XOR;
              3'b110:  w_op = ALU_OR;
              default: w_op = ALU_AND;
            endcase
          end
        endcase
      end

      OPC_OP_IMM: begin
        w_b_imm = 1'b1;
        case (w_funct3)
          3'b000: w_op = ALU_ADD;   // upper bits are immediate: never SUB
          3'b001: begin
            w_op  = ALU_SLL;
            w_ill = !w_f7_base;
          end
          3'b010: w_op = ALU_SLT;
          3'b011: w_op = ALU_SLTU;
          3'b100: w_op = ALU_XOR;
          3'b101: begin
            if (w_f7_alt)       w_op = ALU_SRA;
            else if (w_f7_base) w_op = ALU_SRL;
            else                w_ill = 1'b1;
          end
          3'b110: w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end

      OPC_LOAD, OPC_STORE, OPC_LUI: begin
        w_b_imm = 1'b1;
      end

      OPC_AUIPC: begin
        w_a_pc  = 1'b1;
        w_b_imm = 1'b1;
      end

      OPC_JAL, OPC_JALR: begin
        w_op    = ALU_JUMP;
        w_a_pc  = 1'b1;
        w_b_imm = 1'b1;
      end

      OPC_BRANCH: begin
        w_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_op = ALU_BEQ;
          3'b001:  w_op = ALU_BNE;
          3'b100:  w_op = ALU_SLT;
          3'b101:  w_op = ALU_BGE;
          3'b110:  w_op = ALU_SLTU;
          3'b111:  w_op = ALU_BGEU;
          default: w_ill = 1'b1;
        endcase
      end

      default: w_ill = 1'b1;
    endcase

    // An illegal word carries no meaningful controls downstream
    if (w_ill) begin
      w_op     = ALU_ADD;
      w_a_pc   = 1'b0;
      w_b_imm  = 1'b0;
      w_branch = 1'b0;
    end
  end

  assign o_alu_op    = ALU_OP_WIDTH'(w_op);
  assign o_op_a_pc   = w_a_pc;
  assign o_op_b_imm  = w_b_imm;
  assign o_is_branch = w_branch;
  assign o_illegal   = w_ill;

endmodule : alu_op_decode_comb
`default_nettype wire

// File: rtl/alu_op_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode_stage
//  Description : Registered decode stage producing the ALU operation code and
//                operand-select controls. valid/ready on both sides, one
//                cycle latency, full throughput.
//  Ports       : clock, reset (async active-low), flush (sync kill)
//                in_valid/in_ready/in_instruction/in_pc   - from fetch
//                out_valid/out_ready                      - to execute
//                ALU_operation, op_a_pc, op_b_imm, is_branch, illegal, out_pc
//  Macro       : ALU_DECODE_SKID_EN - when defined, a 2-entry skid buffer with
//                a registered in_ready (no combinational out_ready->in_ready
//                path). Undefined: single register, combinational in_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = alu_pkg::ALU_OP_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_instruction,
  input  logic [DATA_WIDTH-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALU_OP_WIDTH-1:0] ALU_operation,
  output logic                    op_a_pc,
  output logic                    op_b_imm,
  output logic                    is_branch,
  output logic                    illegal,
  output logic [DATA_WIDTH-1:0]   out_pc
);

  localparam int BUNDLE_W = ALU_OP_WIDTH + 4 + DATA_WIDTH;

  logic [ALU_OP_WIDTH-1:0] w_dec_op;
  logic                    w_dec_a_pc;
  logic                    w_dec_b_imm;
  logic                    w_dec_branch;
  logic                    w_dec_illegal;
  logic [BUNDLE_W-1:0]     w_dec_bundle;

  logic                    r_main_valid;
  logic [BUNDLE_W-1:0]     r_main;

  generate
    if (DATA_WIDTH > 32) begin : g_wide_instr
      logic w_unused_hi;
      assign w_unused_hi = ^in_instruction[DATA_WIDTH-1:32];
    end
  endgenerate

  alu_op_decode_comb #(
    .ALU_OP_WIDTH (ALU_OP_WIDTH)
  ) u_decode (
    .i_instr     (in_instruction[31:0]),
    .o_alu_op    (w_dec_op),
    .o_op_a_pc   (w_dec_a_pc),
    .o_op_b_imm  (w_dec_b_imm),
    .o_is_branch (w_dec_branch),
    .o_illegal   (w_dec_illegal)
  );

  assign w_dec_bundle = {w_dec_op, w_dec_a_pc, w_dec_b_imm, w_dec_branch,
                         w_dec_illegal, in_pc};

`ifdef ALU_DECODE_SKID_EN

  logic                r_skid_valid;
  logic [BUNDLE_W-1:0] r_skid;
  logic                r_in_ready;

  logic                w_accept;
  logic                w_xfer;
  logic                w_main_valid_n;
  logic [BUNDLE_W-1:0] w_main_n;
  logic                w_skid_valid_n;
  logic [BUNDLE_W-1:0] w_skid_n;

  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_xfer   = r_main_valid && out_ready;

  always_comb begin
    w_main_valid_n = r_main_valid;
    w_main_n       = r_main;
    w_skid_valid_n = r_skid_valid;
    w_skid_n       = r_skid;

    if (flush) begin
      w_main_valid_n = 1'b0;
      w_skid_valid_n = 1'b0;
    end else if (r_skid_valid) begin
      // in_ready is low here, so only draining is possible: the skid
      // entry moves up into main once the older main entry leaves
      if (w_xfer) begin
        w_main_n       = r_skid;
        w_skid_valid_n = 1'b0;
      end
    end else if (!r_main_valid || w_xfer) begin
      w_main_valid_n = w_accept;
      if (w_accept) w_main_n = w_dec_bundle;
    end else if (w_accept) begin
      // Main is stalled: park the word accepted this cycle
      w_skid_valid_n = 1'b1;
      w_skid_n       = w_dec_bundle;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_n;
      r_main       <= w_main_n;
      r_skid_valid <= w_skid_valid_n;
      r_skid       <= w_skid_n;
      r_in_ready   <= !w_skid_valid_n;
    end
  end

  assign in_ready = r_in_ready;

`else

  logic w_accept;

  assign in_ready = !r_main_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_accept) begin
      r_main_valid <= 1'b1;
      r_main       <= w_dec_bundle;
    end else if (out_ready) begin
      r_main_valid <= 1'b0;
    end
  end

`endif

  assign out_valid = r_main_valid;
  assign {ALU_operation, op_a_pc, op_b_imm, is_branch, illegal, out_pc} = r_main;

endmodule : alu_op_decode_stage
`default_nettype wire

// File: tb/tb_alu_op_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_decode_stage
//  Description : Directed self-checking bench for alu_op_decode_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  ALU_operation;
  logic        op_a_pc;
  logic        op_b_imm;
  logic        is_branch;
  logic        illegal;
  logic [31:0] out_pc;

  logic [10:0] w_ctl;
  assign w_ctl = {out_valid, ALU_operation, op_a_pc, op_b_imm, is_branch, illegal};

  int n_pass  = 0;
  int n_total = 0;
  int sent;
  int got;
  logic s_ir;
  logic s_ov;
  logic [31:0] e_pc;

  alu_op_decode_stage #(
    .DATA_WIDTH   (32),
    .ALU_OP_WIDTH (6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ALU_operation  (ALU_operation),
    .op_a_pc        (op_a_pc),
    .op_b_imm       (op_b_imm),
    .is_branch      (is_branch),
    .illegal        (illegal),
    .out_pc         (out_pc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] ctl(input logic v, input logic [5:0] op, input logic a,
                                      input logic b, input logic br, input logic il);
    return {v, op, a, b, br, il};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid       = v;
    in_instruction = ins;
    in_pc          = pc;
  endtask

  task automatic dec(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [10:0] exp);
    drive(1'b1, ins, pc);
    tick();
    chk(tag, w_ctl, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) tick();
    chk("rst_ctl", w_ctl, 11'd0);
    chk("rst_pc", out_pc, 32'd0);

    // ---------------- async reset mid-stream ----------------
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h80);
    tick();
    chk("pre_rst_valid", out_valid, 1'b1);
    drive(1'b1, 32'h002081B3, 32'h84);
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ctl", w_ctl, 11'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;

    // ---------------- decode vectors ----------------
    dec("add", 32'h002081B3, 32'h100, ctl(1, 0, 0, 0, 0, 0));
    chk("add_pc", out_pc, 32'h100);
    dec("sub",      32'h402081B3, 32'h104, ctl(1, 14, 0, 0, 0, 0));
    dec("srai",     32'h40335293, 32'h108, ctl(1, 13, 0, 1, 0, 0));
    dec("bgeu",     32'h0020F063, 32'h10C, ctl(1, 7, 0, 0, 1, 0));
    dec("br_f3_2",  32'h0020A063, 32'h110, ctl(1, 0, 0, 0, 0, 1));
    dec("jal",      32'h0000006F, 32'h114, ctl(1, 1, 1, 1, 0, 0));
    dec("auipc",    32'h00000097, 32'h118, ctl(1, 0, 1, 1, 0, 0));
    dec("fence",    32'h0000000F, 32'h11C, ctl(1, 0, 0, 0, 0, 1));
    dec("op_f7_1",  32'h022081B3, 32'h120, ctl(1, 0, 0, 0, 0, 1));
    dec("xori",     32'h0030C093, 32'h124, ctl(1, 8, 0, 1, 0, 0));
    dec("sw",       32'h0010A023, 32'h128, ctl(1, 0, 0, 1, 0, 0));
    dec("slli_alt", 32'h40109093, 32'h12C, ctl(1, 0, 0, 0, 0, 1));
    dec("and",      32'h0020F1B3, 32'h130, ctl(1, 10, 0, 0, 0, 0));
    dec("bne",      32'h00209063, 32'h134, ctl(1, 3, 0, 0, 1, 0));
    chk("bne_pc", out_pc, 32'h134);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("drain", out_valid, 1'b0);

    // ---------------- back-pressure: 4 ADDIs, 3-cycle stall ----------------
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (sent < 4) drive(1'b1, 32'h00000093 | (32'(sent) << 20), 32'h200 + 32'(sent * 4));
      else          drive(1'b0, 32'd0, 32'd0);
      #1;
      e_pc = 32'h200 + 32'(got * 4);
      if (out_valid) chk("bp_out", {out_pc, w_ctl}, {e_pc, ctl(1, 0, 0, 1, 0, 0)});
      if (cyc == 2) begin
`ifdef ALU_DECODE_SKID_EN
        chk("bp_ir_stall", in_ready, 1'b1);
`else
        chk("bp_ir_stall", in_ready, 1'b0);
`endif
      end
      s_ir = in_ready;
      s_ov = out_valid;
      @(posedge clock);
      #1;
      if (in_valid && s_ir) sent++;
      if (s_ov && out_ready) got++;
    end
    drive(1'b0, 32'd0, 32'd0);
    chk("bp_got", got, 4);
    chk("bp_sent", sent, 4);
    tick();
    chk("bp_no_dup", out_valid, 1'b0);

    // ---------------- flush ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h300);
    tick();
    chk("fl_pre", out_valid, 1'b1);
    drive(1'b1, 32'h0030C093, 32'h304);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("fl_valid", out_valid, 1'b0);
    tick();
    chk("fl_gone", out_valid, 1'b0);
    out_ready = 1'b1;
    drive(1'b1, 32'h402081B3, 32'h308);
    tick();
    chk("fl_next", {out_pc, w_ctl}, {32'h308, ctl(1, 14, 0, 0, 0, 0)});

    // ---------------- throughput: 8 back-to-back ----------------
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h00000093 | (32'(k) << 20), 32'h400 + 32'(k * 4));
      #1;
      chk("tp_ready", in_ready, 1'b1);
      tick();
      chk("tp_out", {out_pc, w_ctl}, {32'h400 + 32'(k * 4), ctl(1, 0, 0, 1, 0, 0)});
    end
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("tp_end", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alu_op_decode_stage
`default_nettype wire
